io_uart_tx: RTL and testbench
=============================

Name: io_uart_tx

Overview:
- Memory-mapped UART transmitter on the core's I/O bus (io_addr/io_en/io_we/io_data_write/io_data_read). It sits downstream of core_top, alongside io_port.
- Software writes bytes into a small FIFO. The block serialises them as 8N1 frames on `tx` at a programmable bit period.
- It raises a level interrupt when all queued data has been sent.
- Its read data is zero when not addressed, so cpu_top can OR it with io_port's read data.

Parameters:
- BASE_ADDR, 8'h20: byte address of register 0. Registers are word-aligned at BASE_ADDR+0/4/8/12.
- FIFO_DEPTH, 8: TX FIFO entries. Must be a power of 2, 2..16.
- DEFAULT_DIV, 16'd868: reset value of the divisor register.

Ports:
- clk  in  1  system clock.
- resetb  in  1  reset. Asynchronous assert, active-low.
- io_addr  in  8  I/O byte address from the core.
- io_en  in  1  I/O access strobe, one cycle per access.
- io_we  in  1  1 = write, 0 = read. Qualified by io_en.
- io_data_write  in  32  write data.
- io_data_read  out  32  registered read data. 0 when not addressed.
- tx  out  1  serial output. Idle high.
- irq_txempty  out  1  level interrupt: FIFO empty, shifter idle, and enabled.

Behaviour:
- Reset (resetb low, asynchronous):
  - tx=1, io_data_read=0, irq_txempty=0.
  - FIFO empty, overflow=0, divisor=DEFAULT_DIV, ctrl=0, FSM=IDLE.
  - Reset mid-frame aborts the frame immediately and drives tx high.
- Address decode: a register is selected when io_en=1 and io_addr[7:2]==BASE_ADDR[7:2]+off. io_addr[1:0] is ignored.
- Register map:
  - +0 TXDATA: write pushes io_data_write[7:0]. Reads return 0.
  - +4 STATUS (read-only):
    - bit0 full, bit1 empty, bit2 busy (FSM != IDLE), bit3 overflow (sticky).
    - bits[8:4] FIFO count; other bits 0.
    - A read clears overflow on the same edge. An overflow event on that same edge wins and leaves overflow=1.
  - +8 DIV: R/W, bits[15:0]. A write of 0 stores 1. Reads are zero-extended.
  - +12 CTRL: R/W, bit0 irq_en.
- Read timing:
  - io_data_read updates on the edge where io_en=1 and io_we=0. It is valid the cycle after the access.
  - It returns to 0 on the next edge with no selected read.
- FIFO:
  - A push while full is dropped, sets overflow, and leaves FIFO contents unchanged.
  - A push and a pop on the same edge is legal and leaves the count unchanged. When full, the pop happens first, so the push succeeds and no overflow is raised.
  - Pointers wrap modulo FIFO_DEPTH. The count is held separately and ranges 0..FIFO_DEPTH.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop the head into an 8-bit shifter, load baud_cnt=DIV-1, set tx=0, go to START.
  - START/DATA/STOP: baud_cnt decrements each cycle. When baud_cnt==0 it reloads DIV-1 and the bit advances.
  - START to DATA: tx=shifter[0] (LSB first), bit_idx=0.
  - DATA: shift right. After the 8th bit, go to STOP with tx=1.
  - STOP to IDLE: the next frame can start on the following edge, giving a 1-cycle IDLE gap.
  - Each bit lasts exactly DIV cycles. A frame is 10*DIV cycles plus the IDLE cycle.
  - A DIV write mid-frame takes effect at the next reload, not on the current bit.
- Latency: a TXDATA write on edge k with the FIFO empty and FSM IDLE gives a pop and tx=0 on edge k+1.
- irq_txempty: registered; =irq_en & empty & (state==IDLE). It updates the edge after its inputs change.

Test Plan:
- Reset, DIV=4, write TXDATA=0x55 → tx low 4 cycles from edge k+1, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then stop high 4 cycles. STATUS busy=1 during the frame and 0 after.
- FIFO_DEPTH=8, DIV=100, 10 back-to-back writes 0x01..0x0A → first byte pops at once, 8 stored. STATUS reads full=1, overflow=1, count=8. A second STATUS read shows overflow=0. The bytes appear on tx as 0x01..0x09 and 0x0A is lost.
- Write DIV=0 → reads back 1. A write of 0xFF produces a 10-cycle frame with 1 cycle per bit.
- CTRL=1, DIV=2, write 0xA3 → irq_txempty=0 during the frame and 1 within 2 cycles of stop end. Pushing 0x00 drops it again.
- Assert resetb low during DATA bit 3 → tx=1 asynchronously. After release, STATUS=0x2 (empty) and DIV=868.
- Read of an unmapped address (BASE_ADDR+16) and an access with io_en=0 → io_data_read stays 0. Two bytes queued with DIV=3 → tx shows a 1-cycle high gap between frames.

Source files
------------

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO, programmable bit period
// and a level "transmit empty" interrupt. Read data is zero when not addressed.
module io_uart_tx #(
   parameter logic [7:0]  BASE_ADDR   = 8'h20,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
   input  logic        clk,
   input  logic        resetb,
   input  logic [7:0]  io_addr,
   input  logic        io_en,
   input  logic        io_we,
   input  logic [31:0] io_data_write,
   output logic [31:0] io_data_read,
   output logic        tx,
   output logic        irq_txempty
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   logic [7:0]  r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [AW:0] r_count;
   logic        r_ovf, r_irq_en, r_tx, r_irq;
   logic [15:0] r_div, r_baud;
   logic [7:0]  r_shift;
   logic [2:0]  r_bit;
   logic [31:0] r_rdata;
   state_t      r_state;

   logic [5:0]  w_off;
   logic        w_sel, w_wr, w_rd, w_wr_txdata, w_wr_div, w_wr_ctrl, w_rd_status;
   logic        w_empty, w_full, w_pop, w_push, w_ovf_evt;
   logic [15:0] w_div_m1, w_baud_nxt;
   logic [7:0]  w_shift_nxt;
   logic [2:0]  w_bit_nxt;
   logic        w_tx_nxt;
   state_t      w_state_nxt;
   logic [4:0]  w_count5;
   logic [31:0] w_rdata;
   logic        w_unused;

   // Subtraction wraps, so addresses below the base fall outside the 4-register window.
   assign w_off       = io_addr[7:2] - BASE_ADDR[7:2];
   assign w_sel       = io_en & (w_off < 6'd4);
   assign w_wr        = w_sel & io_we;
   assign w_rd        = w_sel & ~io_we;
   assign w_wr_txdata = w_wr & (w_off == 6'd0);
   assign w_rd_status = w_rd & (w_off == 6'd1);
   assign w_wr_div    = w_wr & (w_off == 6'd2);
   assign w_wr_ctrl   = w_wr & (w_off == 6'd3);
   assign w_unused    = &{1'b0, io_addr[1:0], io_data_write[31:16]};

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == FULL_CNT);
   assign w_pop     = (r_state == S_IDLE) & ~w_empty;
   // A same-edge pop frees the slot, so a push into a full FIFO still lands.
   assign w_push    = w_wr_txdata & (~w_full | w_pop);
   assign w_ovf_evt = w_wr_txdata & ~w_push;
   assign w_div_m1  = r_div - 16'd1;
   assign w_count5  = 5'(r_count);

   // FIFO storage
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= io_data_write[7:0];
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW + 1)'(1);
            2'b01:   r_count <= r_count - (AW + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Transmit FSM next-state and datapath
   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud;
      w_shift_nxt = r_shift;
      w_bit_nxt   = r_bit;
      w_tx_nxt    = r_tx;
      case (r_state)
         S_IDLE: begin
            if (w_pop) begin
               w_state_nxt = S_START;
               w_shift_nxt = r_mem[r_rptr];
               w_baud_nxt  = w_div_m1;
               w_tx_nxt    = 1'b0;
            end else begin
               w_tx_nxt    = 1'b1;
            end
         end
         S_START: begin
            if (r_baud == 16'd0) begin
               w_state_nxt = S_DATA;
               w_baud_nxt  = w_div_m1;
               w_tx_nxt    = r_shift[0];
               w_bit_nxt   = 3'd0;
            end else begin
               w_baud_nxt  = r_baud - 16'd1;
            end
         end
         S_DATA: begin
            if (r_baud == 16'd0) begin
               w_baud_nxt = w_div_m1;
               if (r_bit == 3'd7) begin
                  w_state_nxt = S_STOP;
                  w_tx_nxt    = 1'b1;
               end else begin
                  w_shift_nxt = r_shift >> 1;
                  w_tx_nxt    = r_shift[1];
                  w_bit_nxt   = r_bit + 3'd1;
               end
            end else begin
               w_baud_nxt = r_baud - 16'd1;
            end
         end
         S_STOP: begin
            if (r_baud == 16'd0) begin
               w_state_nxt = S_IDLE;
               w_baud_nxt  = w_div_m1;
               w_tx_nxt    = 1'b1;
            end else begin
               w_baud_nxt  = r_baud - 16'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
         end
      endcase
   end

   // Transmit FSM state register
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_state <= S_IDLE;
         r_baud  <= 16'd0;
         r_shift <= 8'd0;
         r_bit   <= 3'd0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_shift <= w_shift_nxt;
         r_bit   <= w_bit_nxt;
         r_tx    <= w_tx_nxt;
      end
   end

   // Read-data mux for the selected register
   always_comb begin
      w_rdata = 32'd0;
      case (w_off[1:0])
         2'd1:    w_rdata = {23'd0, w_count5, r_ovf, (r_state != S_IDLE), w_empty, w_full};
         2'd2:    w_rdata = {16'd0, r_div};
         2'd3:    w_rdata = {31'd0, r_irq_en};
         default: w_rdata = 32'd0;
      endcase
   end

   // Control registers, sticky overflow, read data and interrupt
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_div    <= DEFAULT_DIV;
         r_irq_en <= 1'b0;
         r_ovf    <= 1'b0;
         r_rdata  <= 32'd0;
         r_irq    <= 1'b0;
      end else begin
         if (w_wr_div) begin
            r_div <= (io_data_write[15:0] == 16'd0) ? 16'd1 : io_data_write[15:0];
         end
         if (w_wr_ctrl) begin
            r_irq_en <= io_data_write[0];
         end
         if (w_ovf_evt) begin
            r_ovf <= 1'b1;
         end else if (w_rd_status) begin
            r_ovf <= 1'b0;
         end
         r_rdata <= w_rd ? w_rdata : 32'd0;
         r_irq   <= r_irq_en & w_empty & (r_state == S_IDLE);
      end
   end

   assign io_data_read = r_rdata;
   assign tx           = r_tx;
   assign irq_txempty  = r_irq;

endmodule

// File: tb/tb_io_uart_tx.sv
// Self-checking bench for io_uart_tx: tx is compared every cycle against a
// frame-timing model computed from the queued bytes and the bit period.
module tb_io_uart_tx;

   localparam logic [7:0] A_TX   = 8'h20;
   localparam logic [7:0] A_STAT = 8'h24;
   localparam logic [7:0] A_DIV  = 8'h28;
   localparam logic [7:0] A_CTRL = 8'h2C;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        resetb = 1'b0;
   logic [7:0]  io_addr = 8'h00;
   logic        io_en = 1'b0;
   logic        io_we = 1'b0;
   logic [31:0] io_data_write = 32'd0;
   logic [31:0] io_data_read;
   logic        tx;
   logic        irq_txempty;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] mon_q[$];
   int         mon_div = 1;
   int         mon_j = 0;
   bit         mon_on = 1'b0;

   io_uart_tx dut (
      .clk(clk), .resetb(resetb), .io_addr(io_addr), .io_en(io_en), .io_we(io_we),
      .io_data_write(io_data_write), .io_data_read(io_data_read), .tx(tx),
      .irq_txempty(irq_txempty)
   );

   always #5 clk = ~clk;

   // Line level j samples after the first start-bit edge: frames of 10 bits plus one idle cycle.
   function automatic logic exp_tx(int j);
      int p, f, r, b;
      logic [7:0] v;
      if (j < 0) return 1'b1;
      p = 10 * mon_div + 1;
      f = j / p;
      r = j % p;
      if (f >= mon_q.size()) return 1'b1;
      b = r / mon_div;
      v = mon_q[f];
      if (b == 0) return 1'b0;
      if (b <= 8) return v[b-1];
      return 1'b1;
   endfunction

   task automatic tick();
      logic e;
      @(negedge clk);
      if (mon_on) begin
         e = exp_tx(mon_j);
         n_vec++;
         if (tx !== e) begin
            n_err++;
            $display("FAIL tx_line j=%0d div=%0d: got %b expected %b", mon_j, mon_div, tx, e);
         end
         mon_j++;
      end
   endtask

   task automatic io_write(input logic [7:0] a, input logic [31:0] d);
      io_addr = a; io_data_write = d; io_we = 1'b1; io_en = 1'b1;
      tick();
      io_en = 1'b0; io_we = 1'b0;
   endtask

   task automatic io_read(input logic [7:0] a, output logic [31:0] d);
      io_addr = a; io_we = 1'b0; io_en = 1'b1;
      tick();
      d = io_data_read;
      io_en = 1'b0;
   endtask

   task automatic start_mon(input int div);
      mon_div = div; mon_j = -1; mon_on = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      resetb = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b expected 1", tx); end
      n_vec++; if (io_data_read !== 32'd0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", io_data_read); end
      n_vec++; if (irq_txempty !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", irq_txempty); end
      resetb = 1'b1;
      tick();
      io_read(A_STAT, d);
      n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL reset_status: got %h expected 2", d); end
      io_read(A_DIV, d);
      n_vec++; if (d !== 32'd868) begin n_err++; $display("FAIL reset_div: got %0d expected 868", d); end
      io_read(A_CTRL, d);
      n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_ctrl: got %h expected 0", d); end
   endtask

   task automatic test_frame_55();
      logic [31:0] d;
      io_write(A_DIV, 32'd4);
      mon_q = {8'h55};
      start_mon(4);
      io_write(A_TX, 32'h55);
      repeat (10) tick();
      io_read(A_STAT, d);
      n_vec++; if (d !== 32'h6) begin n_err++; $display("FAIL busy_status: got %h expected 6", d); end
      while (mon_j < 10 * 4 + 3) tick();
      mon_on = 1'b0;
      io_read(A_STAT, d);
      n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL idle_status: got %h expected 2", d); end
   endtask

   task automatic test_div_zero();
      logic [31:0] d;
      io_write(A_DIV, 32'd0);
      io_read(A_DIV, d);
      n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL div_zero: got %0d expected 1", d); end
      mon_q = {8'hFF};
      start_mon(1);
      io_write(A_TX, 32'hFF);
      while (mon_j < 13) tick();
      mon_on = 1'b0;
   endtask

   task automatic test_random_frames();
      int d, n;
      repeat (4) begin
         d = $urandom_range(1, 6);
         n = $urandom_range(1, 3);
         io_write(A_DIV, 32'(d));
         mon_q.delete();
         for (int i = 0; i < n; i++) mon_q.push_back(8'($urandom));
         start_mon(d);
         for (int i = 0; i < n; i++) io_write(A_TX, {24'd0, mon_q[i]});
         while (mon_j < n * (10 * d + 1) + 2) tick();
         mon_on = 1'b0;
      end
   endtask

   task automatic test_irq();
      logic [31:0] d;
      int j;
      logic e;
      io_write(A_DIV, 32'd2);
      io_write(A_CTRL, 32'd1);
      tick();
      n_vec++; if (irq_txempty !== 1'b1) begin n_err++; $display("FAIL irq_enable: got %b expected 1", irq_txempty); end
      io_read(A_CTRL, d);
      n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL ctrl_read: got %h expected 1", d); end
      mon_q = {8'hA3};
      start_mon(2);
      io_write(A_TX, 32'hA3);
      n_vec++; if (irq_txempty !== 1'b1) begin n_err++; $display("FAIL irq_push_edge: got %b expected 1", irq_txempty); end
      // Interrupt is low while data is queued or in flight, high two edges after the stop bit ends.
      while (mon_j <= 22) begin
         tick();
         j = mon_j - 1;
         e = (j >= 0 && j <= 20) ? 1'b0 : 1'b1;
         n_vec++;
         if (irq_txempty !== e) begin
            n_err++; $display("FAIL irq_frame j=%0d: got %b expected %b", j, irq_txempty, e);
         end
      end
      mon_q = {8'h00};
      start_mon(2);
      io_write(A_TX, 32'h00);
      tick();
      n_vec++; if (irq_txempty !== 1'b0) begin n_err++; $display("FAIL irq_drop: got %b expected 0", irq_txempty); end
      while (mon_j < 23) tick();
      mon_on = 1'b0;
      io_write(A_CTRL, 32'd0);
      tick();
      n_vec++; if (irq_txempty !== 1'b0) begin n_err++; $display("FAIL irq_disable: got %b expected 0", irq_txempty); end
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      io_write(A_DIV, 32'd100);
      // The first byte leaves the FIFO at once, DEPTH more fit, the rest of the burst is lost.
      mon_q.delete();
      for (int i = 1; i <= DEPTH + 1; i++) mon_q.push_back(8'(i));
      start_mon(100);
      for (int i = 1; i <= DEPTH + 2; i++) io_write(A_TX, 32'(i));
      io_read(A_STAT, d);
      n_vec++; if (d !== 32'h8D) begin n_err++; $display("FAIL ovf_status1: got %h expected 8d", d); end
      io_read(A_STAT, d);
      n_vec++; if (d !== 32'h85) begin n_err++; $display("FAIL ovf_status2: got %h expected 85", d); end
      while (mon_j < (DEPTH + 1) * 1001 + 2) tick();
      mon_on = 1'b0;
      io_read(A_STAT, d);
      n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL ovf_drained: got %h expected 2", d); end
   endtask

   task automatic test_unmapped_gap();
      logic [31:0] d;
      io_read(8'h27, d);
      n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL status_alias: got %h expected 2", d); end
      io_read(8'h30, d);
      n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL unmapped_read: got %h expected 0", d); end
      io_read(A_STAT, d);
      io_addr = A_STAT; io_we = 1'b0; io_en = 1'b0;
      tick();
      n_vec++; if (io_data_read !== 32'd0) begin n_err++; $display("FAIL no_enable_read: got %h expected 0", io_data_read); end
      io_read(A_TX, d);
      n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL txdata_read: got %h expected 0", d); end
      io_write(A_DIV, 32'd3);
      mon_q = {8'($urandom), 8'($urandom)};
      start_mon(3);
      io_write(A_TX, {24'd0, mon_q[0]});
      io_write(A_TX, {24'd0, mon_q[1]});
      while (mon_j < 2 * 31 + 2) tick();
      mon_on = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] d;
      logic [7:0] b;
      b = 8'($urandom) & 8'hF7;
      io_write(A_DIV, 32'd4);
      mon_q = {b};
      start_mon(4);
      io_write(A_TX, {24'd0, b});
      while (mon_j < 4 * 4 + 2) tick();
      mon_on = 1'b0;
      #2 resetb = 1'b0;
      #1;
      n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL async_reset_tx: got %b expected 1", tx); end
      tick();
      resetb = 1'b1;
      tick();
      io_read(A_STAT, d);
      n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL post_reset_status: got %h expected 2", d); end
      io_read(A_DIV, d);
      n_vec++; if (d !== 32'd868) begin n_err++; $display("FAIL post_reset_div: got %0d expected 868", d); end
   endtask

   initial begin
      test_reset();
      test_frame_55();
      test_div_zero();
      test_random_frames();
      test_irq();
      test_overflow();
      test_unmapped_gap();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
